// File: rtl/spi_cfg_slave.sv
// SPI configuration slave: 40-bit frames (8-bit address, 32-bit data) sampled on clk,
// writing six trading configuration registers and shifting register readback out on spi_miso.
module spi_cfg_slave (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    output logic        spi_miso,
    output logic [31:0] buy_limit,
    output logic [31:0] sell_limit,
    output logic [31:0] buy_qty,
    output logic [31:0] sell_qty,
    output logic [1:0]  trade_mode,
    output logic [15:0] arb_multiplier,
    output logic        cfg_update,
    output logic        frame_err,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic        r_mosi_s1, r_mosi_s2;
    logic        r_cs_s1, r_cs_s2, r_cs_d;
    logic [1:0]  r_vld;
    logic        r_armed;
    logic [5:0]  r_bit_cnt;
    logic [30:0] r_shift_in;
    logic [7:0]  r_addr;
    logic [31:0] r_shift_out;
    logic        r_rd_act;
    logic [31:0] r_buy_limit, r_sell_limit, r_buy_qty, r_sell_qty;
    logic [1:0]  r_trade_mode;
    logic [15:0] r_arb;
    logic        r_cfg_update, r_frame_err;

    logic        w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic        w_in_frame, w_bit, w_last;
    logic [7:0]  w_addr8;
    logic [31:0] w_data;
    logic [31:0] w_rdback;

    // Two-flop synchronizers; r_vld marks when the sync pipeline reflects the pins after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_cs_d    <= 1'b1;
            r_vld     <= 2'b00;
            r_armed   <= 1'b0;
        end else begin
            r_sclk_s1 <= spi_sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_mosi_s1 <= spi_mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_cs_s1   <= spi_cs_n;
            r_cs_s2   <= r_cs_s1;
            r_cs_d    <= r_cs_s2;
            r_vld     <= {r_vld[0], 1'b1};
            if (r_vld[1] && r_cs_s2)
                r_armed <= 1'b1;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
    assign w_cs_fall   = ~r_cs_s2 & r_cs_d;
    assign w_cs_rise   = r_cs_s2 & ~r_cs_d;
    assign w_in_frame  = (r_state == ADDR) || (r_state == DATA);
    // A rise coinciding with the cs_n rise is still accepted so a tight 40th bit commits.
    assign w_bit       = w_sclk_rise & w_in_frame & ~(r_cs_s2 & r_cs_d);
    assign w_last      = w_bit & (r_bit_cnt == 6'd39);
    assign w_addr8     = {r_shift_in[6:0], r_mosi_s2};
    assign w_data      = {r_shift_in, r_mosi_s2};

    always_comb begin
        w_rdback = '0;
        case (w_addr8[6:0])
            7'd0:    w_rdback = r_buy_limit;
            7'd1:    w_rdback = r_sell_limit;
            7'd2:    w_rdback = r_buy_qty;
            7'd3:    w_rdback = r_sell_qty;
            7'd4:    w_rdback = {30'd0, r_trade_mode};
            7'd5:    w_rdback = {16'd0, r_arb};
            default: w_rdback = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_shift_in   <= '0;
            r_addr       <= '0;
            r_shift_out  <= '0;
            r_rd_act     <= 1'b0;
            r_buy_limit  <= '0;
            r_sell_limit <= '0;
            r_buy_qty    <= '0;
            r_sell_qty   <= '0;
            r_trade_mode <= 2'd0;
            r_arb        <= 16'd16;
            r_cfg_update <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_cfg_update <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_rd_act && w_sclk_fall && (r_state == DATA || r_state == HOLD))
                r_shift_out <= {r_shift_out[30:0], 1'b0};
            case (r_state)
                IDLE: begin
                    if (r_armed && w_cs_fall) begin
                        r_state   <= ADDR;
                        r_bit_cnt <= '0;
                        r_rd_act  <= 1'b0;
                    end
                end
                ADDR, DATA: begin
                    if (w_bit) begin
                        r_shift_in <= {r_shift_in[29:0], r_mosi_s2};
                        r_bit_cnt  <= r_bit_cnt + 6'd1;
                        if (r_bit_cnt == 6'd7) begin
                            r_addr  <= w_addr8;
                            r_state <= DATA;
                            if (w_addr8[7]) begin
                                r_shift_out <= w_rdback;
                                r_rd_act    <= 1'b1;
                            end
                        end
                        if (w_last) begin
                            r_state <= HOLD;
                            if (!r_addr[7]) begin
                                case (r_addr[6:0])
                                    7'd0: begin r_buy_limit  <= w_data; r_cfg_update <= 1'b1; end
                                    7'd1: begin r_sell_limit <= w_data; r_cfg_update <= 1'b1; end
                                    7'd2: begin r_buy_qty    <= w_data; r_cfg_update <= 1'b1; end
                                    7'd3: begin r_sell_qty   <= w_data; r_cfg_update <= 1'b1; end
                                    7'd4: begin
                                        if (w_data[1:0] == 2'd3) begin
                                            r_frame_err <= 1'b1;
                                        end else begin
                                            r_trade_mode <= w_data[1:0];
                                            r_cfg_update <= 1'b1;
                                        end
                                    end
                                    7'd5:    begin r_arb <= w_data[15:0]; r_cfg_update <= 1'b1; end
                                    default: r_frame_err <= 1'b1;
                                endcase
                            end
                        end
                    end
                    if (w_cs_rise) begin
                        r_state  <= IDLE;
                        r_rd_act <= 1'b0;
                        if (!w_last)
                            r_frame_err <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_cs_rise) begin
                        r_state  <= IDLE;
                        r_rd_act <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign spi_miso       = r_rd_act & r_shift_out[31] & ~r_cs_s2;
    assign buy_limit      = r_buy_limit;
    assign sell_limit     = r_sell_limit;
    assign buy_qty        = r_buy_qty;
    assign sell_qty       = r_sell_qty;
    assign trade_mode     = r_trade_mode;
    assign arb_multiplier = r_arb;
    assign cfg_update     = r_cfg_update;
    assign frame_err      = r_frame_err;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_spi_cfg_slave.sv
// Bench for spi_cfg_slave: directed frame table, mid-frame reset, then random frames
// checked against a register-map model.
`timescale 1ns/100ps
module tb_spi_cfg_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_miso;
  logic [31:0] buy_limit, sell_limit, buy_qty, sell_qty;
  logic [1:0]  trade_mode;
  logic [15:0] arb_multiplier;
  logic        cfg_update, frame_err;
  logic [1:0]  o_dbg_state;

  spi_cfg_slave dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .spi_miso(spi_miso), .buy_limit(buy_limit),
    .sell_limit(sell_limit), .buy_qty(buy_qty), .sell_qty(sell_qty),
    .trade_mode(trade_mode), .arb_multiplier(arb_multiplier),
    .cfg_update(cfg_update), .frame_err(frame_err), .o_dbg_state(o_dbg_state)
  );

  // clock / reset / cycle count
  always #0.5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // pulse monitor
  int upd_cnt = 0;
  int err_cnt = 0;
  int unsigned pulse_cyc = 0;
  always @(negedge clk) begin
    if (cfg_update) upd_cnt++;
    if (frame_err) err_cnt++;
    if (cfg_update || frame_err) pulse_cyc = cyc;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: sim time exceeded, got timeout required completion");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_mis = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // reference model: register map plus expected readback queue
  logic [31:0] m_regs[6];
  logic [31:0] exp_q[$];

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) m_regs[i] = 32'd0;
    m_regs[5] = 32'd16;
  endfunction

  task automatic model_frame(input logic [7:0] a, input logic [31:0] d, input int nb,
                             output int e_upd, output int e_err);
    int idx;
    idx = int'(a[6:0]);
    e_upd = 0;
    e_err = 0;
    if (nb < 40) e_err = 1;
    else if (a[7]) exp_q.push_back(idx < 6 ? m_regs[idx] : 32'd0);
    else if (idx > 5) e_err = 1;
    else if (idx == 4 && d[1:0] == 2'd3) e_err = 1;
    else begin
      m_regs[idx] = (idx == 4) ? (d % 4) : (idx == 5) ? (d % 65536) : d;
      e_upd = 1;
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_buy_limit"}, buy_limit, m_regs[0]);
    chk({tag, "_sell_limit"}, sell_limit, m_regs[1]);
    chk({tag, "_buy_qty"}, buy_qty, m_regs[2]);
    chk({tag, "_sell_qty"}, sell_qty, m_regs[3]);
    chk({tag, "_trade_mode"}, {30'd0, trade_mode}, m_regs[4]);
    chk({tag, "_arb_mult"}, {16'd0, arb_multiplier}, m_regs[5]);
  endtask

  task automatic reset_check();
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    chk_regs("rst");
    chk("rst_cfg_update", {31'd0, cfg_update}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_miso", {31'd0, spi_miso}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // driver: one frame; half sclk period = 8 clk
  int unsigned r40 = 0;
  task automatic spi_frame(input logic [7:0] a, input logic [31:0] d, input int nb,
                           input int extra, input bit cs_last, input int rst_at,
                           output logic [31:0] rd_word);
    logic [39:0] f;
    f = {a, d};
    rd_word = 32'd0;
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < nb; b++) begin
      if (b == rst_at) reset_check();
      spi_mosi = f[39-b];
      repeat (8) @(negedge clk);
      spi_sclk = 1'b1;
      if (b == 39) begin
        r40 = cyc;
        if (cs_last) spi_cs_n = 1'b1;
      end
      repeat (8) @(negedge clk);
      if (b >= 7 && b <= 38) rd_word = {rd_word[30:0], spi_miso};
      spi_sclk = 1'b0;
    end
    for (int k = 0; k < extra; k++) begin
      repeat (8) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (8) @(negedge clk);
      spi_sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic apply(input logic [7:0] a, input logic [31:0] d, input int nb, input int extra,
                       input bit cs_last, input bit use_tbl, input int t_upd, input int t_err,
                       input logic [31:0] t_rd);
    int m_upd, m_err, u0, e0, lat;
    logic [31:0] rd, m_rd;
    u0 = upd_cnt;
    e0 = err_cnt;
    model_frame(a, d, nb, m_upd, m_err);
    spi_frame(a, d, nb, extra, cs_last, -1, rd);
    if (use_tbl) begin
      m_upd = t_upd;
      m_err = t_err;
    end
    chk("cfg_update_pulses", upd_cnt - u0, m_upd);
    chk("frame_err_pulses", err_cnt - e0, m_err);
    if (nb == 40 && !a[7] && (m_upd + m_err) > 0) begin
      lat = int'(pulse_cyc - r40);
      chk("commit_latency_1to4", {31'd0, (lat >= 1 && lat <= 4)}, 32'd1);
    end
    if (nb == 40 && a[7]) begin
      m_rd = exp_q.pop_front();
      chk("miso_readback", rd, use_tbl ? t_rd : m_rd);
    end
    chk("miso_idle_zero", {31'd0, spi_miso}, 32'd0);
    chk_regs("regs");
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          nb;
    int          extra;
    bit          cs_last;
    int          e_upd;
    int          e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [31:0] rd;
    int u0;
    tbl[0]  = '{8'h00, 32'd42500, 40, 0, 1'b0, 1, 0, 32'd0};
    tbl[1]  = '{8'h02, 32'd3,     40, 0, 1'b0, 1, 0, 32'd0};
    tbl[2]  = '{8'h04, 32'd1,     40, 0, 1'b0, 1, 0, 32'd0};
    tbl[3]  = '{8'h05, 32'd18,    40, 0, 1'b0, 1, 0, 32'd0};
    tbl[4]  = '{8'h85, 32'd0,     40, 0, 1'b0, 0, 0, 32'h12};
    tbl[5]  = '{8'h01, 32'd45000, 20, 0, 1'b0, 0, 1, 32'd0};
    tbl[6]  = '{8'h01, 32'd45000, 40, 0, 1'b0, 1, 0, 32'd0};
    tbl[7]  = '{8'h09, 32'd5,     40, 0, 1'b0, 0, 1, 32'd0};
    tbl[8]  = '{8'h04, 32'd3,     40, 0, 1'b0, 0, 1, 32'd0};
    tbl[9]  = '{8'h03, 32'd2,     40, 8, 1'b0, 1, 0, 32'd0};
    tbl[10] = '{8'h02, 32'd7,     40, 0, 1'b1, 1, 0, 32'd0};
    tbl[11] = '{8'h84, 32'd0,     40, 0, 1'b0, 0, 0, 32'd1};
    tbl[12] = '{8'h8A, 32'hFFFF,  40, 0, 1'b0, 0, 0, 32'd0};
    tbl[13] = '{8'h80, 32'd0,     40, 0, 1'b0, 0, 0, 32'd42500};
    tbl[14] = '{8'h03, 32'd9,     0,  0, 1'b0, 0, 1, 32'd0};

    model_reset();
    repeat (4) @(negedge clk);
    chk_regs("reset");
    chk("reset_cfg_update", {31'd0, cfg_update}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_miso", {31'd0, spi_miso}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 15; i++)
      apply(tbl[i].addr, tbl[i].data, tbl[i].nb, tbl[i].extra, tbl[i].cs_last,
            1'b1, tbl[i].e_upd, tbl[i].e_err, tbl[i].e_rd);

    // reset during bit 30 of a write; the rest of that frame must be ignored
    u0 = upd_cnt;
    spi_frame(8'h00, 32'd43000, 40, 0, 1'b0, 29, rd);
    chk("rstmid_no_update", upd_cnt - u0, 32'd0);
    chk_regs("rstmid");
    apply(8'h00, 32'd43000, 40, 0, 1'b0, 1'b1, 1, 0, 32'd0);

    for (int i = 0; i < 30; i++) begin
      logic [7:0]  a;
      logic [31:0] d;
      int          nb;
      a  = {($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 7'($urandom_range(0, 7))};
      d  = $urandom;
      if (a[6:0] == 7'd4 && $urandom_range(0, 1) == 1) d[1:0] = 2'd3;
      nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 39)) : 40;
      apply(a, d, nb, int'($urandom_range(0, 3)), 1'b0, 1'b0, 0, 0, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
